multdiv_iter: RTL and testbench
===============================

// Module: multdiv_iter
// PURPOSE
//  Iterative signed 32-bit multiply/divide unit in the execute stage of the 2-wide core.
//  Accepts one MULT or DIV per start pulse and produces a 32-bit result plus a destination tag.
//  The result feeds the 32-bit result register, written with ctrl_writeEnable = data_resultRDY.
//  One op is in flight at a time. Issue stalls while data_inputRDY is low.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH
//  TAG_W  5   destination register index width
// PORTS
//  clock           in   1      rising-edge clock
//  ctrl_reset      in   1      asynchronous reset, active-low (0 = reset)
//  ctrl_MULT       in   1      start signed multiply; sampled when data_inputRDY=1
//  ctrl_DIV        in   1      start signed divide; sampled when data_inputRDY=1
//  data_operandA   in   WIDTH  multiplicand / dividend
//  data_operandB   in   WIDTH  multiplier / divisor
//  in_tag          in   TAG_W  destination reg index, captured at start
//  data_inputRDY   out  1      1 = IDLE, can accept a start
//  data_result     out  WIDTH  product low word / quotient; held until next completion
//  data_exception  out  1      overflow or divide-by-zero; valid with data_resultRDY
//  data_resultRDY  out  1      one-cycle completion pulse
//  out_tag         out  TAG_W  captured in_tag; valid with data_resultRDY
// BEHAVIOUR
//  Reset (async, ctrl_reset=0): state=IDLE, counter=0.
//   data_inputRDY=1. data_result=0, data_exception=0, data_resultRDY=0, out_tag=0.
//  FSM: IDLE -> MULT | DIV -> FIX -> DONE -> IDLE.
//   IDLE: start seen at edge k latches operand magnitudes, result sign, in_tag, counter=0.
//   MULT: radix-2 shift-add, 1 bit/cycle, WIDTH cycles, 2*WIDTH-bit accumulator.
//   DIV: restoring shift-subtract, 1 quotient bit/cycle, WIDTH cycles.
//   FIX: apply sign (two's complement negate) and compute the exception.
//   DONE: data_resultRDY=1 for exactly one cycle, then IDLE.
//  Latency: start at edge k -> data_resultRDY high in the cycle after edge k+WIDTH+2 (34 for 32).
//  data_inputRDY is 0 from edge k until DONE returns to IDLE.
//  data_inputRDY is 1 in the cycle after the resultRDY pulse; back-to-back issue is allowed there.
//  Start arbitration:
//   - Both ctrl_MULT and ctrl_DIV high: MULT wins.
//   - Starts while busy: ignored, with no effect on the in-flight op.
//  MULT: signed 64-bit product. data_result = low 32 bits.
//   data_exception=1 iff bits[63:31] are not all equal (result does not fit signed 32-bit).
//  DIV: quotient truncated toward zero; remainder discarded.
//   - Divisor 0: skip iterations. IDLE->FIX->DONE, resultRDY at edge k+2.
//     data_result=0, data_exception=1.
//   - 0x80000000 / -1: data_result=0x80000000, data_exception=1.
//  data_result, data_exception and out_tag update only at the FIX->DONE edge.
//  They hold until the next completion.
//  Reset asserted mid-op aborts the op immediately: all outputs take reset values, no resultRDY.
//  Operand inputs may change after the start cycle without affecting the op.
// STRUCTURE
//  Include multdiv_defs.vh:
//   - FSM state localparams: IDLE=3'd0, MULT=3'd1, DIV=3'd2, FIX=3'd3, DONE=3'd4
//   - MULT_DIV_ITERS = WIDTH
//  Sub-module mdu_counter: 6-bit up-counter with clear/enable, terminal flag at WIDTH-1.
//  Datapath (accumulator, shifter, add/sub, negate) stays in multdiv_iter.
// TESTING
//  1. MULT 7 x -6 -> resultRDY at 34 cycles; result 0xFFFFFFD6 (-42), exc=0, out_tag=in_tag.
//  2. MULT 0x00010000 x 0x00010000 -> result 0x00000000, exc=1 (overflow).
//  3. DIV -7 / 2 -> result 0xFFFFFFFD (-3), exc=0; DIV 100 / 0 -> resultRDY 2 cycles later,
//     result 0, exc=1.
//  4. DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exc=1.
//  5. Contention: ctrl_MULT=ctrl_DIV=1, A=6, B=3 -> result 18 (MULT wins);
//     extra ctrl_DIV pulses while busy -> ignored, exactly one resultRDY.
//  6. Reset low at cycle 10 of a MULT -> outputs zero, data_inputRDY=1, no resultRDY pulse.
//     Release, issue MULT 3 x 5 -> result 15 after 34 cycles.

Source files
------------

// File: rtl/multdiv_iter_pkg.sv
// rtl/multdiv_iter_pkg.sv - shared types and constants for the iterative multiply/divide unit
package multdiv_iter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 5;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/multdiv_iter_if.sv
// rtl/multdiv_iter_if.sv - issue/completion bundle between the core and the multiply/divide unit
interface multdiv_iter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [TAG_W-1:0] in_tag;
  logic             data_inputRDY;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, in_tag,
    input  data_inputRDY, data_result, data_exception, data_resultRDY, out_tag
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, in_tag,
    output data_inputRDY, data_result, data_exception, data_resultRDY, out_tag
  );
endinterface

// File: rtl/multdiv_iter_counter.sv
// rtl/multdiv_iter_counter.sv - iteration counter with clear/enable and last-iteration flag
module mdu_counter
  import multdiv_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  logic [CNT_W-1:0] count;

  // count iterations; clear has priority so every op starts from zero
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative signed multiply/divide, one bit per cycle, one op in flight
module multdiv_iter
  import multdiv_iter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input logic           clock,
  input logic           ctrl_reset,
  multdiv_iter_if.slave bus
);
  localparam int MULT_DIV_ITERS = WIDTH;

  state_t               state, state_nxt;
  logic                 input_rdy, accept;
  logic                 cnt_clear, cnt_enable, cnt_term;
  logic [WIDTH-1:0]     abs_a, abs_b, mag_a, mag_b;
  logic                 neg, is_div, dbz;
  logic [TAG_W-1:0]     tag;
  logic [2*WIDTH-1:0]   acc, acc_mul, acc_div, prod_s;
  logic [WIDTH:0]       mul_sum, div_shift, div_trial, prod_hi;
  logic [WIDTH-1:0]     quo_s, fix_result;
  logic                 fix_exc;
  logic [WIDTH-1:0]     result_q;
  logic                 exc_q, rdy_q;
  logic [TAG_W-1:0]     tag_q;

  mdu_counter #(.WIDTH(MULT_DIV_ITERS)) u_cnt (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .clear      (cnt_clear),
    .enable     (cnt_enable),
    .terminal   (cnt_term)
  );

  // input_rdy stays low through the completion pulse so a new op cannot overlap it
  assign input_rdy = (state == IDLE) && !rdy_q;
  assign accept    = input_rdy && (bus.ctrl_MULT || bus.ctrl_DIV);
  assign abs_a     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  // multiply step: conditionally add multiplicand to the high half, then shift right
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
  assign acc_mul = {mul_sum, acc[WIDTH-1:1]};

  // divide step: acc = {remainder, dividend/quotient}; shift in next dividend bit and trial-subtract
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, mag_b};
  assign acc_div   = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // sign fix-up and exception; quotient magnitude 2^(WIDTH-1) only fits when negative
  assign prod_s     = neg ? -acc : acc;
  assign quo_s      = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign prod_hi    = prod_s[2*WIDTH-1:WIDTH-1];
  assign fix_result = !is_div ? prod_s[WIDTH-1:0] : (dbz ? '0 : quo_s);
  assign fix_exc    = !is_div ? !((&prod_hi) || !(|prod_hi))
                              : (dbz || (!neg && acc[WIDTH-1]));

  // state register
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  // next-state: MULT has priority; a zero divisor skips straight to FIX
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
              if (bus.ctrl_MULT)                state_nxt = MULT;
              else if (bus.data_operandB == '0) state_nxt = FIX;
              else                              state_nxt = DIV;
            end
      MULT, DIV: if (cnt_term) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: counter control
  always_comb begin
    cnt_clear  = (state == IDLE);
    cnt_enable = (state == MULT) || (state == DIV);
  end

  // operand capture at start and per-cycle accumulator update
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      is_div <= 1'b0;
      dbz    <= 1'b0;
      tag    <= '0;
      acc    <= '0;
    end else if (accept) begin
      mag_a  <= abs_a;
      mag_b  <= abs_b;
      neg    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      is_div <= !bus.ctrl_MULT;
      dbz    <= !bus.ctrl_MULT && (bus.data_operandB == '0);
      tag    <= bus.in_tag;
      acc    <= {{WIDTH{1'b0}}, (bus.ctrl_MULT ? abs_b : abs_a)};
    end else if (state == MULT) begin
      acc <= acc_mul;
    end else if (state == DIV) begin
      acc <= acc_div;
    end
  end

  // result registers load on leaving FIX; completion pulse follows DONE
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      result_q <= '0;
      exc_q    <= 1'b0;
      tag_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      if (state == FIX) begin
        result_q <= fix_result;
        exc_q    <= fix_exc;
        tag_q    <= tag;
      end
      rdy_q <= (state == DONE);
    end
  end

  assign bus.data_inputRDY  = input_rdy;
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.out_tag        = tag_q;
endmodule

// File: tb/tb_multdiv_iter.sv
// tb/tb_multdiv_iter.sv - directed and scoreboarded bench for multdiv_iter
module tb_multdiv_iter;
  localparam int W  = 32;
  localparam int TW = 5;

  typedef struct packed {
    logic [W-1:0]  result;
    logic          exc;
    logic [TW-1:0] tag;
  } exp_t;

  logic clock = 1'b0;
  logic ctrl_reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  multdiv_iter_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  multdiv_iter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] t);
    exp_t   e;
    longint p;
    int     lo;
    int     q;
    e.tag = t;
    if (m) begin
      p = longint'(signed'(a)) * longint'(signed'(b));
      lo = p[31:0];
      e.result = p[31:0];
      e.exc = (p != longint'(lo));
    end else if (b == '0) begin
      e.result = '0;
      e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.result = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      q = signed'(a) / signed'(b);
      e.result = q;
      e.exc = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.data_inputRDY && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_ready"}, 64'(bus.data_inputRDY), 64'd1);
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int   lat = 0;
    bit   seen = 0;
    exp_t e;
    while (!seen && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (bus.data_resultRDY) seen = 1;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_result"}, 64'(bus.data_result), 64'(e.result));
      check({name, "_exc"}, 64'(bus.data_exception), 64'(e.exc));
      check({name, "_tag"}, 64'(bus.out_tag), 64'(e.tag));
      @(posedge clock); #1;
      check({name, "_pulse_end"}, 64'(bus.data_resultRDY), 64'd0);
      check({name, "_ready_after"}, 64'(bus.data_inputRDY), 64'd1);
    end else begin
      sb.delete();
    end
  endtask

  task automatic run_op(input string name, input logic m, input logic d, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] t, input int exp_lat);
    wait_ready(name);
    bus.ctrl_MULT = m;
    bus.ctrl_DIV = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.in_tag = t;
    sb.push_back(model(m, a, b, t));
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    bus.in_tag = TW'($urandom);
    check({name, "_busy"}, 64'(bus.data_inputRDY), 64'd0);
    wait_result(name, exp_lat);
  endtask

  initial begin
    int            pulses;
    int            lat;
    exp_t          e;
    logic          m;
    logic [W-1:0]  a;
    logic [W-1:0]  b;

    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.in_tag = '0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_input_rdy", 64'(bus.data_inputRDY), 64'd1);
    check("reset_result", 64'(bus.data_result), 64'd0);
    check("reset_exc", 64'(bus.data_exception), 64'd0);
    check("reset_result_rdy", 64'(bus.data_resultRDY), 64'd0);
    check("reset_out_tag", 64'(bus.out_tag), 64'd0);
    ctrl_reset = 1'b1;
    @(posedge clock); #1;

    run_op("mul_7x-6", 1, 0, 32'd7, 32'hFFFF_FFFA, 5'd3, 34);
    run_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 5'd4, 34);
    run_op("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 5'd5, 34);
    run_op("div_by_0", 0, 1, 32'd100, 32'd0, 5'd6, 2);
    run_op("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 34);
    run_op("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 5'd8, 34);
    run_op("mul_min_by_1", 1, 0, 32'h8000_0000, 32'd1, 5'd10, 34);

    for (int i = 0; i < 6; i++) begin
      m = i[0];
      a = $urandom;
      b = (i == 2) ? 32'd0 : ($urandom >> (i * 5));
      run_op("random", m, !m, a, b, TW'(i + 20), (!m && b == '0) ? 2 : 34);
    end

    // contention: both starts high, then stray DIV pulses while busy
    wait_ready("contend");
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV = 1'b1;
    bus.data_operandA = 32'd6;
    bus.data_operandB = 32'd3;
    bus.in_tag = 5'd9;
    sb.push_back(model(1'b1, 32'd6, 32'd3, 5'd9));
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    pulses = 0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5 || c == 12) begin
        bus.ctrl_DIV = 1'b1;
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
        bus.in_tag = 5'd1;
      end else begin
        bus.ctrl_DIV = 1'b0;
      end
      @(posedge clock); #1;
      if (bus.data_resultRDY) begin
        pulses++;
        lat = c;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("contend_result", 64'(bus.data_result), 64'(e.result));
          check("contend_tag", 64'(bus.out_tag), 64'(e.tag));
        end
      end
    end
    check("contend_pulses", 64'(pulses), 64'd1);
    check("contend_latency", 64'(lat), 64'd34);
    check("contend_idle", 64'(bus.data_inputRDY), 64'd1);
    sb.delete();

    // reset in the middle of a multiply
    wait_ready("abort");
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = 32'h0000_1234;
    bus.data_operandB = 32'h0000_0055;
    bus.in_tag = 5'd12;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    #1;
    check("abort_input_rdy", 64'(bus.data_inputRDY), 64'd1);
    check("abort_result", 64'(bus.data_result), 64'd0);
    check("abort_exc", 64'(bus.data_exception), 64'd0);
    check("abort_out_tag", 64'(bus.out_tag), 64'd0);
    check("abort_result_rdy", 64'(bus.data_resultRDY), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    ctrl_reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY) pulses++;
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);

    run_op("mul_3x5", 1, 0, 32'd3, 32'd5, 5'd13, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
